// File: rtl/key_debounce_pkg.sv
// Shared constants for the key conditioner: board clock, debounce window,
// and the helper that turns them into a stability count.
package key_debounce_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 1;

  // Number of clk samples spanning the debounce window.
  function automatic int calc_stable_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key lane: synchroniser, stability counter, level register, edge pulses.
module key_debounce_channel #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 0,
  parameter int CNT_W         = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_debounced,
  output logic key_pressed,
  output logic key_released
);

  localparam logic             IDLE    = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   pr_q, pr_d;
  logic                   rl_q, rl_d;
  logic                   s;

  // Synchroniser chain; resets to the idle raw level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{IDLE}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], key};
  end

  // Polarity-normalised synchronised sample, 1 = pressed.
  assign s = sync_q[SYNC_STAGES-1] ^ IDLE;

  // Next state: count while the sample disagrees, accept on the last count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    pr_d  = 1'b0;
    rl_d  = 1'b0;
    if (s != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s;
        pr_d  = s;
        rl_d  = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any partial count and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
      pr_q  <= 1'b0;
      rl_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
      pr_q  <= pr_d;
      rl_q  <= rl_d;
    end
  end

  assign key_debounced = deb_q;
  assign key_pressed   = pr_q;
  assign key_released  = rl_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner; one independent lane per key.
module key_debounce_multi
  import key_debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = calc_stable_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key,
  output logic [CHANNELS-1:0] key_debounced,
  output logic [CHANNELS-1:0] key_pressed,
  output logic [CHANNELS-1:0] key_released
);

  // Counter only has to reach STABLE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  generate
    if (CHANNELS < 1)                       begin : g_bad_ch  $error("CHANNELS must be >= 1");      end
    if (SYNC_STAGES < 2)                    begin : g_bad_syn $error("SYNC_STAGES must be >= 2");   end
    if (STABLE_CYCLES < 1)                  begin : g_bad_stb $error("STABLE_CYCLES must be >= 1"); end
    if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_al  $error("ACTIVE_LOW must be 0 or 1"); end
  endgenerate

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    key_debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .key           (key[i]),
      .key_debounced (key_debounced[i]),
      .key_pressed   (key_pressed[i]),
      .key_released  (key_released[i])
    );
  end

endmodule
